// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and constants for the audio capture path
//
// Provides the recorder state encoding and the default SRAM address/sample widths.

package aud_pkg;

    localparam int AUD_ADDR_W = 20;
    localparam int AUD_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_LRC = 3'd1,
        S_SKIP     = 3'd2,
        S_SHIFT    = 3'd3,
        S_WRITE    = 3'd4,
        S_PAUSE    = 3'd5
    } aud_state_t;

endpackage

// File: rtl/aud_if.sv
// rtl/aud_if.sv - SRAM write-side bus between the recorder and the SRAM arbiter
//
// Signals:
//   sram_addr  word address of the slot being written
//   sram_data  sample to write
//   sram_we_n  active-low write strobe, one cycle per sample
// Modports: master (recorder drives), slave (arbiter observes).

interface aud_if
    import aud_pkg::*;
#(
    parameter int ADDR_W = AUD_ADDR_W,
    parameter int DATA_W = AUD_DATA_W
);
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic              sram_we_n;

    modport master (
        output sram_addr,
        output sram_data,
        output sram_we_n
    );

    modport slave (
        input sram_addr,
        input sram_data,
        input sram_we_n
    );
endinterface

// File: rtl/aud_sync_edge.sv
// rtl/aud_sync_edge.sv - two-flop synchronizer with rise/fall pulse outputs
//
// Ports:
//   i_clk, i_rst_n  system clock, asynchronous active-low reset
//   i_async         pin from another clock domain
//   o_data          synchronized level
//   o_rise, o_fall  one-cycle pulses on synchronized edges

module aud_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_data,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_data = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/aud_recorder.sv
// rtl/aud_recorder.sv - I2S left-channel capture into SRAM with start/pause/stop
//
// Ports:
//   i_clk, i_rst_n            system clock (>= 4x bclk), asynchronous active-low reset
//   i_start/i_pause/i_stop    one-cycle command pulses (stop > pause > start)
//   i_bclk, i_lrc, i_adcdat   codec ADC pins, asynchronous to i_clk
//   sram                      SRAM write bus (addr, data, we_n)
//   o_stop_addr               sample count of the last completed recording
//   o_busy                    recorder not idle
//   o_full                    last recording ended at MAX_ADDR

module aud_recorder
    import aud_pkg::*;
#(
    parameter int              ADDR_W   = AUD_ADDR_W,
    parameter int              DATA_W   = AUD_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_lrc,
    input  logic              i_adcdat,
    aud_if.master             sram,
    output logic [ADDR_W-1:0] o_stop_addr,
    output logic              o_busy,
    output logic              o_full
);
    localparam int CNT_W = $clog2(DATA_W);

    logic w_bclk_rise;
    logic w_lrc_fall;
    logic w_dat;
    logic w_unused_bclk_data;
    logic w_unused_bclk_fall;
    logic w_unused_lrc_data;
    logic w_unused_lrc_rise;
    logic w_unused_dat_rise;
    logic w_unused_dat_fall;

    aud_sync_edge u_sync_bclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_bclk),
        .o_data  (w_unused_bclk_data),
        .o_rise  (w_bclk_rise),
        .o_fall  (w_unused_bclk_fall)
    );

    aud_sync_edge u_sync_lrc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_lrc),
        .o_data  (w_unused_lrc_data),
        .o_rise  (w_unused_lrc_rise),
        .o_fall  (w_lrc_fall)
    );

    // Data and bclk share the same synchronizer depth, so w_dat is aligned
    // with w_bclk_rise.
    aud_sync_edge u_sync_dat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_adcdat),
        .o_data  (w_dat),
        .o_rise  (w_unused_dat_rise),
        .o_fall  (w_unused_dat_fall)
    );

    aud_state_t        r_state;
    aud_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bitcnt;
    logic              r_we_n;
    logic [ADDR_W-1:0] r_stop_addr;
    logic              r_full;

    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_stop_val;
    logic              w_clr;
    logic              w_inc;
    logic              w_stop;
    logic              w_set_full;
    logic              w_load;
    logic              w_bit_clr;
    logic              w_shift_en;

    assign w_addr_inc = r_addr + 1'b1;

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_inc      = 1'b0;
        w_stop     = 1'b0;
        w_stop_val = r_addr;
        w_set_full = 1'b0;
        w_load     = 1'b0;
        w_bit_clr  = 1'b0;
        w_shift_en = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_WAIT_LRC;
                    w_clr  = 1'b1;
                end
            end
            S_WAIT_LRC: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_stop = 1'b1;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else if (w_lrc_fall) begin
                    w_next = S_SKIP;
                end
            end
            S_SKIP: begin
                // I2S places the MSB one bclk after the LRC edge.
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_stop = 1'b1;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else if (w_bclk_rise) begin
                    w_next    = S_SHIFT;
                    w_bit_clr = 1'b1;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_stop = 1'b1;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else if (w_bclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == CNT_W'(DATA_W - 1)) begin
                        w_next = S_WRITE;
                        w_load = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // The write always commits; commands act after the increment.
                w_inc = 1'b1;
                if (w_addr_inc == MAX_ADDR) begin
                    w_next     = S_IDLE;
                    w_set_full = 1'b1;
                    w_stop     = 1'b1;
                    w_stop_val = MAX_ADDR;
                end else if (i_stop) begin
                    w_next     = S_IDLE;
                    w_stop     = 1'b1;
                    w_stop_val = w_addr_inc;
                end else if (i_pause) begin
                    w_next = S_PAUSE;
                end else begin
                    w_next = S_WAIT_LRC;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                    w_stop = 1'b1;
                end else if (i_start) begin
                    w_next = S_WAIT_LRC;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_we_n      <= 1'b1;
            r_stop_addr <= '0;
            r_full      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Strobe is low exactly for the cycle spent in S_WRITE.
            r_we_n  <= ~w_load;

            if (w_clr) begin
                r_addr <= '0;
                r_full <= 1'b0;
            end else if (w_inc) begin
                r_addr <= w_addr_inc;
            end

            if (w_set_full) r_full <= 1'b1;
            if (w_stop) r_stop_addr <= w_stop_val;

            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            if (w_shift_en) r_shift <= {r_shift[DATA_W-2:0], w_dat};
            if (w_load) r_data <= {r_shift[DATA_W-2:0], w_dat};
        end
    end

    assign sram.sram_addr  = r_addr;
    assign sram.sram_data  = r_data;
    assign sram.sram_we_n  = r_we_n;
    assign o_stop_addr     = r_stop_addr;
    assign o_busy          = (r_state != S_IDLE);
    assign o_full          = r_full;

endmodule

// File: tb/tb_aud_recorder.sv
// tb/tb_aud_recorder.sv - scoreboard bench for aud_recorder

`timescale 1ns/1ps

module tb_aud_recorder;
    import aud_pkg::*;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
    logic i_start2 = 1'b0, i_pause2 = 1'b0, i_stop2 = 1'b0;
    logic i_bclk = 1'b1, i_lrc = 1'b1, i_adcdat = 1'b0;

    logic [19:0] stop1, stop2;
    logic        busy1, busy2, full1, full2;

    aud_if #(.ADDR_W(20), .DATA_W(16)) sram1 ();
    aud_if #(.ADDR_W(20), .DATA_W(16)) sram2 ();

    aud_recorder dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_bclk(i_bclk), .i_lrc(i_lrc), .i_adcdat(i_adcdat),
        .sram(sram1), .o_stop_addr(stop1), .o_busy(busy1), .o_full(full1)
    );

    aud_recorder #(.MAX_ADDR(20'd4)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_start(i_start2), .i_pause(i_pause2), .i_stop(i_stop2),
        .i_bclk(i_bclk), .i_lrc(i_lrc), .i_adcdat(i_adcdat),
        .sram(sram2), .o_stop_addr(stop2), .o_busy(busy2), .o_full(full2)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] q1[$];
    logic [35:0] q2[$];

    always @(negedge i_clk) begin
        if (i_rst_n && sram1.sram_we_n === 1'b0) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_errors++;
                $display("FAIL write1_unexpected addr=%h data=%h", sram1.sram_addr, sram1.sram_data);
            end else begin
                logic [35:0] e;
                e = q1.pop_front();
                if ({sram1.sram_addr, sram1.sram_data} !== e) begin
                    n_errors++;
                    $display("FAIL write1 got addr=%h data=%h expected addr=%h data=%h",
                             sram1.sram_addr, sram1.sram_data, e[35:16], e[15:0]);
                end
            end
        end
        if (i_rst_n && sram2.sram_we_n === 1'b0) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_errors++;
                $display("FAIL write2_unexpected addr=%h data=%h", sram2.sram_addr, sram2.sram_data);
            end else begin
                logic [35:0] e;
                e = q2.pop_front();
                if ({sram2.sram_addr, sram2.sram_data} !== e) begin
                    n_errors++;
                    $display("FAIL write2 got addr=%h data=%h expected addr=%h data=%h",
                             sram2.sram_addr, sram2.sram_data, e[35:16], e[15:0]);
                end
            end
        end
    end

    function automatic logic frame_bit(input int s, input logic [15:0] l, input logic [15:0] r);
        if (s >= 1 && s <= 16) return l[16-s];
        if (s >= 21 && s <= 36) return r[36-s];
        return 1'b0;
    endfunction

    // One bclk period: data and lrc change on the falling edge.
    task automatic slot(input int s, input logic [15:0] l, input logic [15:0] r);
        i_lrc    = (s >= 20);
        i_adcdat = frame_bit(s, l, r);
        i_bclk   = 1'b0;
        #40;
        i_bclk   = 1'b1;
        #40;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        for (int s = 0; s < 40; s++) slot(s, l, r);
    endtask

    task automatic pulse(input int which);
        @(negedge i_clk);
        case (which)
            0: i_start = 1'b1;
            1: i_pause = 1'b1;
            2: i_stop = 1'b1;
            3: i_start2 = 1'b1;
            4: i_stop2 = 1'b1;
            default: ;
        endcase
        @(negedge i_clk);
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        i_start2 = 1'b0; i_stop2 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({sram1.sram_addr, sram1.sram_data, sram1.sram_we_n, stop1, busy1, full1} !==
            {20'd0, 16'd0, 1'b1, 20'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values got addr=%h data=%h we_n=%b stop=%h busy=%b full=%b",
                     sram1.sram_addr, sram1.sram_data, sram1.sram_we_n, stop1, busy1, full1);
        end
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (busy1 !== 1'b0 || sram1.sram_we_n !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_idle got busy=%b we_n=%b expected 0/1", busy1, sram1.sram_we_n);
        end
    endtask

    task automatic test_basic;
        pulse(0);
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_errors++;
            $display("FAIL start_busy got %b expected 1", busy1);
        end
        q1.push_back({20'd0, 16'h8001});
        send_frame(16'h8001, 16'hFFFF);
        q1.push_back({20'd1, 16'h7FFE});
        send_frame(16'h7FFE, 16'hFFFF);
        q1.push_back({20'd2, 16'h1234});
        send_frame(16'h1234, 16'hFFFF);
        n_checks++;
        if (q1.size() != 0 || sram1.sram_addr !== 20'd3) begin
            n_errors++;
            $display("FAIL basic_done got addr=%h pending=%0d expected addr=3 pending=0",
                     sram1.sram_addr, q1.size());
        end
    endtask

    task automatic test_pause;
        for (int s = 0; s < 9; s++) slot(s, 16'h5555, 16'hFFFF);
        pulse(1);
        for (int s = 9; s < 40; s++) slot(s, 16'h5555, 16'hFFFF);
        n_checks++;
        if (sram1.sram_addr !== 20'd3 || busy1 !== 1'b1) begin
            n_errors++;
            $display("FAIL pause_hold got addr=%h busy=%b expected addr=3 busy=1", sram1.sram_addr, busy1);
        end
        pulse(0);
        q1.push_back({20'd3, 16'hABCD});
        send_frame(16'hABCD, 16'hFFFF);
        n_checks++;
        if (q1.size() != 0 || sram1.sram_addr !== 20'd4) begin
            n_errors++;
            $display("FAIL resume got addr=%h pending=%0d expected addr=4 pending=0",
                     sram1.sram_addr, q1.size());
        end
    endtask

    task automatic test_stop_restart;
        pulse(2);
        n_checks++;
        if (stop1 !== 20'd4 || busy1 !== 1'b0 || full1 !== 1'b0) begin
            n_errors++;
            $display("FAIL stop got stop_addr=%h busy=%b full=%b expected 4/0/0", stop1, busy1, full1);
        end
        pulse(0);
        q1.push_back({20'd0, 16'h0F0F});
        send_frame(16'h0F0F, 16'hFFFF);
        n_checks++;
        if (stop1 !== 20'd4 || sram1.sram_addr !== 20'd1 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL restart got stop_addr=%h addr=%h pending=%0d expected 4/1/0",
                     stop1, sram1.sram_addr, q1.size());
        end
        pulse(2);
        n_checks++;
        if (stop1 !== 20'd1) begin
            n_errors++;
            $display("FAIL second_stop got stop_addr=%h expected 1", stop1);
        end
    endtask

    task automatic test_full;
        pulse(3);
        for (int k = 0; k < 4; k++) q2.push_back({20'(k), 16'(16'h1000 + k)});
        for (int k = 0; k < 6; k++) send_frame(16'(16'h1000 + k), 16'hFFFF);
        n_checks++;
        if (full2 !== 1'b1 || stop2 !== 20'd4 || busy2 !== 1'b0 || q2.size() != 0) begin
            n_errors++;
            $display("FAIL full got full=%b stop_addr=%h busy=%b pending=%0d expected 1/4/0/0",
                     full2, stop2, busy2, q2.size());
        end
    endtask

    task automatic test_coincident;
        logic hit;
        hit = 1'b0;
        pulse(0);
        q1.push_back({20'd0, 16'hAAAA});
        q1.push_back({20'd1, 16'h5555});
        q1.push_back({20'd2, 16'hC3C3});
        fork
            begin
                send_frame(16'hAAAA, 16'hFFFF);
                send_frame(16'h5555, 16'hFFFF);
                send_frame(16'hC3C3, 16'hFFFF);
            end
            begin
                for (int k = 0; k < 4000 && !hit; k++) begin
                    @(negedge i_clk);
                    if (sram1.sram_we_n === 1'b0 && sram1.sram_addr === 20'd2) begin
                        i_stop  = 1'b1;
                        i_pause = 1'b1;
                        @(negedge i_clk);
                        i_stop  = 1'b0;
                        i_pause = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL coincident_timeout got no write at addr 2 expected one");
        end
        n_checks++;
        if (stop1 !== 20'd3 || busy1 !== 1'b0 || full1 !== 1'b0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL coincident got stop_addr=%h busy=%b full=%b pending=%0d expected 3/0/0/0",
                     stop1, busy1, full1, q1.size());
        end
        send_frame(16'h7777, 16'hFFFF);
        n_checks++;
        if (busy1 !== 1'b0 || sram1.sram_addr !== 20'd3) begin
            n_errors++;
            $display("FAIL idle_ignores got busy=%b addr=%h expected 0/3", busy1, sram1.sram_addr);
        end
    endtask

    task automatic test_reset_mid;
        pulse(0);
        q1.push_back({20'd0, 16'h3C3C});
        send_frame(16'h3C3C, 16'hFFFF);
        for (int s = 0; s < 9; s++) slot(s, 16'h5A5A, 16'hFFFF);
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sram1.sram_addr, sram1.sram_data, sram1.sram_we_n, stop1, busy1, full1} !==
            {20'd0, 16'd0, 1'b1, 20'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_mid got addr=%h data=%h we_n=%b stop=%h busy=%b full=%b",
                     sram1.sram_addr, sram1.sram_data, sram1.sram_we_n, stop1, busy1, full1);
        end
        n_checks++;
        if (full2 !== 1'b0 || stop2 !== 20'd0) begin
            n_errors++;
            $display("FAIL reset_mid_dut2 got full=%b stop=%h expected 0/0", full2, stop2);
        end
        n_checks++;
        if (q1.size() != 0) begin
            n_errors++;
            $display("FAIL reset_mid_pending got %0d expected 0", q1.size());
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_pause;
        test_stop_restart;
        test_full;
        test_coincident;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
Capture side of the audio path: deserializes the codec ADC's I2S left-channel samples and writes them into the external SRAM at consecutive word addresses. It supports start, pause and stop. On stop it publishes the end address, which the playback DSP uses as its stop address. It sits between the codec ADC pins and the SRAM arbiter, mirroring the playback block's read side.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, sample width.
- MAX_ADDR, 20'hFFFFF, first address never written; recording auto-stops when the address reaches it.

Ports:
- i_clk  in  1  system clock; must be at least 4x i_bclk frequency.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start a new recording (from IDLE) or resume (from PAUSE); one-cycle pulse.
- i_pause  in  1  pause; one-cycle pulse.
- i_stop  in  1  stop; one-cycle pulse.
- i_bclk  in  1  codec ADC bit clock, asynchronous to i_clk.
- i_lrc  in  1  codec ADCLRCK; low = left channel.
- i_adcdat  in  1  codec ADC serial data, MSB first.
- o_sram_addr  out  ADDR_W  write address; equals the next free slot.
- o_sram_data  out  DATA_W  sample to write.
- o_sram_we_n  out  1  active-low write strobe, one cycle wide.
- o_stop_addr  out  ADDR_W  number of samples in the last completed recording.
- o_busy  out  1  high in any state other than S_IDLE.
- o_full  out  1  last recording ended because MAX_ADDR was reached.

Behaviour:
- Reset values: o_sram_addr=0, o_sram_data=0, o_sram_we_n=1, o_stop_addr=0, o_busy=0, o_full=0, state S_IDLE.
- Synchronization:
  - i_bclk, i_lrc and i_adcdat each pass through a 2-flop synchronizer.
  - Rising edges of bclk and the falling edge of lrc are detected on the synchronized signals.
  - i_adcdat is sampled on the detected bclk rising edge.
- States:
  - S_IDLE: i_start -> clear address to 0, clear o_full -> S_WAIT_LRC.
  - S_WAIT_LRC: lrc falling edge -> S_SKIP.
  - S_SKIP: I2S one-bit delay; first bclk rise is ignored -> S_SHIFT, bit counter=0.
  - S_SHIFT: on each bclk rise, shift i_adcdat into LSB; after the 16th bit -> S_WRITE.
  - S_WRITE: exactly one cycle.
    - o_sram_we_n=0; o_sram_data holds the shifted word; o_sram_addr holds the current slot.
    - Next cycle: address+1, then -> S_WAIT_LRC.
  - S_PAUSE: address held. i_start -> S_WAIT_LRC without clearing the address.
- Pause: from S_WAIT_LRC, S_SKIP or S_SHIFT, i_pause -> S_PAUSE. Any partially shifted sample is discarded.
- Stop: from any non-IDLE state, i_stop -> S_IDLE. o_stop_addr <= address, after any increment made in the same cycle.
- Right-channel half frames are ignored entirely.
- Priority for simultaneous commands: stop > pause > start.
- Write commit: a sample that has reached S_WRITE is always committed. Stop or pause in the S_WRITE cycle takes effect after the write and increment.
- Full:
  - If the incremented address equals MAX_ADDR, the next state is S_IDLE, o_full=1 and o_stop_addr=MAX_ADDR.
  - MAX_ADDR itself is never written.
- o_stop_addr changes only on the stop or full transition. It holds its value through a new recording.
- Latency: o_sram_we_n falls 1 i_clk after the cycle in which the synchronized 16th bclk rise is detected (about 3-4 i_clk after the raw pin edge).
- Asynchronous reset mid-operation: all outputs return to reset values immediately; o_sram_we_n is forced high.

Decomposition:
- Shared package aud_pkg:
  - state enum (S_IDLE, S_WAIT_LRC, S_SKIP, S_SHIFT, S_WRITE, S_PAUSE);
  - constants AUD_ADDR_W=20 and AUD_DATA_W=16.
- One sub-module, aud_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs. Instantiated once each for bclk, lrc and adcdat (data output only).

Test Plan:
- Reset: hold i_rst_n low mid-stream -> addr=0, data=0, we_n=1, stop_addr=0, busy=0, full=0.
- Basic capture: start, then drive left samples 16'h8001, 16'h7FFE, 16'h1234 with right = 16'hFFFF -> three we_n pulses at addr 0,1,2 with exactly those data, no write for right; o_sram_addr=3.
- Pause mid-sample: pause after 8 bits of the 4th frame -> no write, addr stays 3; start, then frame 16'hABCD -> written at addr 3, o_sram_addr=4.
- Stop and restart: stop -> o_stop_addr=4, busy=0. New start, one frame -> written at addr 0 while o_stop_addr stays 4.
- Full: MAX_ADDR=4, feed 6 frames -> exactly 4 writes (addr 0..3), o_full=1, o_stop_addr=4, state S_IDLE.
- Coincident stop: i_stop and i_pause asserted together in the S_WRITE cycle of the sample at addr 2 -> write committed, o_stop_addr=3, state S_IDLE (not S_PAUSE).
